bcd2binary_seq: RTL

- Sequential BCD-to-binary converter using reverse double-dabble: shift right one bit per clock, then apply a "subtract 3" correction to each digit.
- Inverse of the combinational binary-to-BCD block. Score and timer digits entered or held in BCD on the board are converted back to binary for comparison and arithmetic.
- Uses a start/busy/done handshake. Performs one conversion at a time.

---
 rtl/bcd_pkg.sv | 32 +++
 rtl/bcd_digit_correct.sv | 16 +
 rtl/bcd2binary_seq.sv | 148 ++++++++++++++
 3 files changed

// File: rtl/bcd_pkg.sv
`default_nettype none
// ==========================================================================
// bcd_pkg : shared constants and state encoding for BCD-to-binary logic
// Rev 1.0
// ==========================================================================
package bcd_pkg;

  localparam int         DIGIT_W       = 4;
  localparam logic [3:0] BCD_DIGIT_MAX = 4'd9;
  localparam logic [3:0] CORR_THRESH   = 4'd8;
  localparam logic [3:0] CORR_SUB      = 4'd3;

  typedef enum logic [0:0] {
    IDLE  = 1'b0,
    SHIFT = 1'b1
  } state_e;

  // True when a bin_w-bit result can hold every value of a digits-wide BCD number.
  function automatic bit width_ok(input int digits, input int bin_w);
    longint p10;
    p10 = 1;
    for (int i = 0; i < digits; i++) begin
      p10 = p10 * 10;
    end
    if (bin_w >= 62) begin
      return 1'b1;
    end
    return ((longint'(1) << bin_w) >= p10);
  endfunction

endpackage
`default_nettype wire

// File: rtl/bcd_digit_correct.sv
`default_nettype none
// ==========================================================================
// bcd_digit_correct : one reverse double-dabble cell (subtract 3 when >= 8)
// Rev 1.0
// ==========================================================================
module bcd_digit_correct
  import bcd_pkg::*;
(
  input  logic [DIGIT_W-1:0] din,
  output logic [DIGIT_W-1:0] dout
);

  assign dout = (din >= CORR_THRESH) ? (din - CORR_SUB) : din;

endmodule
`default_nettype wire

// File: rtl/bcd2binary_seq.sv
`default_nettype none
// ==========================================================================
// bcd2binary_seq : sequential BCD-to-binary converter, one bit per clock
// Rev 1.0
// ==========================================================================
module bcd2binary_seq
  import bcd_pkg::*;
#(
  parameter int DIGITS = 3,
  parameter int BIN_W  = 10
) (
  input  logic                        clk,
  input  logic                        reset,
  input  logic                        start,
  input  logic [DIGIT_W*DIGITS-1:0]   bcd,
  output logic                        busy,
  output logic                        done,
  output logic [BIN_W-1:0]            binary,
  output logic                        err
);

  localparam int              BCD_W     = DIGIT_W * DIGITS;
  localparam int              CNT_W     = (BIN_W > 1) ? $clog2(BIN_W) : 1;
  localparam logic [CNT_W-1:0] LAST_STEP = CNT_W'(BIN_W - 1);

  if (!width_ok(DIGITS, BIN_W)) begin : g_width_check
    $error("bcd2binary_seq: BIN_W too narrow for DIGITS");
  end

  state_e               state_q, state_d;
  logic [BCD_W-1:0]     digits_q, digits_d;
  logic [BIN_W-1:0]     acc_q, acc_d;
  logic [CNT_W-1:0]     count_q, count_d;
  logic                 err_next_q, err_next_d;
  logic [BIN_W-1:0]     binary_q, binary_d;
  logic                 err_q, err_d;
  logic                 done_q, done_d;

  logic [BCD_W-1:0]     shifted_digits;
  logic [BCD_W-1:0]     corrected_digits;
  logic [BIN_W-1:0]     shifted_acc;
  logic                 bcd_invalid;
  logic                 last_step;

  // {digits, acc} >> 1 : the digit LSB falls into the accumulator MSB
  assign shifted_digits = digits_q >> 1;
  assign shifted_acc    = {digits_q[0], acc_q[BIN_W-1:1]};
  assign last_step      = (count_q == LAST_STEP);

  for (genvar i = 0; i < DIGITS; i++) begin : g_digit
    bcd_digit_correct u_corr (
      .din  (shifted_digits[i*DIGIT_W +: DIGIT_W]),
      .dout (corrected_digits[i*DIGIT_W +: DIGIT_W])
    );
  end

  always_comb begin
    bcd_invalid = 1'b0;
    for (int i = 0; i < DIGITS; i++) begin
      if (bcd[i*DIGIT_W +: DIGIT_W] > BCD_DIGIT_MAX) begin
        bcd_invalid = 1'b1;
      end
    end
  end

  // State register
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // Next-state logic
  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    if (start)     state_d = SHIFT;
      SHIFT:   if (last_step) state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // Output logic
  always_comb begin
    busy = (state_q == SHIFT);
  end

  always_comb begin
    digits_d   = digits_q;
    acc_d      = acc_q;
    count_d    = count_q;
    err_next_d = err_next_q;
    binary_d   = binary_q;
    err_d      = err_q;
    done_d     = 1'b0;
    case (state_q)
      IDLE: begin
        if (start) begin
          digits_d   = bcd;
          acc_d      = '0;
          count_d    = '0;
          err_next_d = bcd_invalid;
        end
      end
      SHIFT: begin
        digits_d = corrected_digits;
        acc_d    = shifted_acc;
        count_d  = count_q + 1'b1;
        if (last_step) begin
          // Invalid input still runs all steps so latency stays constant.
          binary_d = err_next_q ? '0 : shifted_acc;
          err_d    = err_next_q;
          done_d   = 1'b1;
          count_d  = '0;
        end
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      digits_q   <= '0;
      acc_q      <= '0;
      count_q    <= '0;
      err_next_q <= 1'b0;
      binary_q   <= '0;
      err_q      <= 1'b0;
      done_q     <= 1'b0;
    end else begin
      digits_q   <= digits_d;
      acc_q      <= acc_d;
      count_q    <= count_d;
      err_next_q <= err_next_d;
      binary_q   <= binary_d;
      err_q      <= err_d;
      done_q     <= done_d;
    end
  end

  assign done   = done_q;
  assign binary = binary_q;
  assign err    = err_q;

endmodule
`default_nettype wire
